// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding, owner codes
// and the data word returned on an aborted (timed-out) access.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_EX = 1'b1;

    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of EX grants taken while IF was waiting. Once it reaches
// STARVE_MAX the next contended grant must go to IF (force_if).
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_if,
    input  logic grant_ex,
    input  logic if_waiting,
    output logic force_if
);

    logic [3:0] cnt_q, cnt_d;

    // Clear on an IF grant, count EX grants that bypassed a waiting IF.
    always_comb begin
        cnt_d = cnt_q;
        if (grant_if) begin
            cnt_d = 4'd0;
        end else if (grant_ex && if_waiting && (cnt_q != 4'(STARVE_MAX))) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 4'd0;
        else     cnt_q <= cnt_d;
    end

    assign force_if = (cnt_q == 4'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (IF read-only, EX load/store) in front of a single
// ported memory. IDLE -> BUSY -> RESP -> IDLE; EX has priority unless IF has
// been bypassed STARVE_MAX times in a row.
// Optional MEM_TIMEOUT_EN: abort a BUSY access after TIMEOUT cycles without
// mem_ack, returning TIMEOUT_DATA with err=1.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              ex_req,
    input  logic              ex_we,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic [DATA_W-1:0] ex_rdata,
    output logic              ex_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              owner,
    output logic              busy,
    output logic              err
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_MAX must be 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT must be 1..15");
    end

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ex_rdata_q, ex_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              ex_ready_q, ex_ready_d;
    logic              busy_q, busy_d;
    logic              grant_if, grant_ex;
    logic              force_if;
`ifdef MEM_TIMEOUT_EN
    logic              err_q, err_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
`endif

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .grant_if   (grant_if),
        .grant_ex   (grant_ex),
        .if_waiting (if_req),
        .force_if   (force_if)
    );

    // Next-state logic: arbitrate in IDLE, wait for ack in BUSY, one-cycle RESP.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ex_rdata_d  = ex_rdata_q;
        if_ready_d  = 1'b0;
        ex_ready_d  = 1'b0;
        grant_if    = 1'b0;
        grant_ex    = 1'b0;
`ifdef MEM_TIMEOUT_EN
        err_d       = 1'b0;
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef MEM_TIMEOUT_EN
                wait_cnt_d = 4'd0;
`endif
                if (if_req && (!ex_req || force_if)) begin
                    grant_if   = 1'b1;
                    owner_d    = OWN_IF;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    mem_req_d  = 1'b1;
                    state_d    = ST_BUSY;
                end else if (ex_req) begin
                    grant_ex    = 1'b1;
                    owner_d     = OWN_EX;
                    mem_we_d    = ex_we;
                    mem_addr_d  = ex_addr;
                    mem_wdata_d = ex_wdata;
                    mem_req_d   = 1'b1;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    // Stores leave both rdata registers untouched.
                    if (!mem_we_q) begin
                        if (owner_q == OWN_EX) ex_rdata_d = mem_rdata;
                        else                   if_rdata_d = mem_rdata;
                    end
                    if (owner_q == OWN_EX) ex_ready_d = 1'b1;
                    else                   if_ready_d = 1'b1;
                    state_d = ST_RESP;
                end
`ifdef MEM_TIMEOUT_EN
                else if (wait_cnt_q == 4'(TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (owner_q == OWN_EX) begin
                        ex_rdata_d = DATA_W'(TIMEOUT_DATA);
                        ex_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = DATA_W'(TIMEOUT_DATA);
                        if_ready_d = 1'b1;
                    end
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; async reset drops any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            ex_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            ex_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ex_rdata_q  <= ex_rdata_d;
            if_ready_q  <= if_ready_d;
            ex_ready_q  <= ex_ready_d;
            busy_q      <= busy_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Timeout bookkeeping: BUSY wait counter and the abort flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            wait_cnt_q <= 4'd0;
        end else begin
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign owner     = owner_q;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign ex_rdata  = ex_rdata_q;
    assign if_ready  = if_ready_q;
    assign ex_ready  = ex_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table for basic
// load/store/fetch/contention, then hand sequences for starvation, slow
// memory, reset mid-access and (with MEM_TIMEOUT_EN) the timeout abort.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ex_req, ex_we, mem_ack;
    logic [7:0]  if_addr, ex_addr;
    logic [15:0] ex_wdata, mem_rdata;
    logic [15:0] if_rdata, ex_rdata, mem_wdata;
    logic [7:0]  mem_addr;
    logic        if_ready, ex_ready, mem_req, mem_we, owner, busy, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(8), .DATA_W(16), .STARVE_MAX(4), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_rdata(ex_rdata), .ex_ready(ex_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .owner(owner), .busy(busy), .err(err)
    );

    typedef struct {
        logic        if_req;
        logic [7:0]  if_addr;
        logic        ex_req;
        logic        ex_we;
        logic [7:0]  ex_addr;
        logic [15:0] ex_wdata;
        logic        ack;
        logic [15:0] rdata;
        logic [63:0] exp;
    } vec_t;

    vec_t tv [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {1'b0, if_rdata, ex_rdata, mem_addr, mem_wdata,
                mem_req, mem_we, if_ready, ex_ready, owner, busy, err};
    endfunction

    function automatic vec_t mk(
        input logic ir, input logic [7:0] ia, input logic er, input logic ew,
        input logic [7:0] ea, input logic [15:0] ed, input logic ak, input logic [15:0] rd,
        input logic e_mreq, input logic e_we, input logic [7:0] e_addr, input logic [15:0] e_wd,
        input logic e_ifr, input logic e_exr, input logic [15:0] e_ifd, input logic [15:0] e_exd,
        input logic e_own, input logic e_busy);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.ex_req = er; v.ex_we = ew;
        v.ex_addr = ea; v.ex_wdata = ed; v.ack = ak; v.rdata = rd;
        v.exp = {1'b0, e_ifd, e_exd, e_addr, e_wd, e_mreq, e_we, e_ifr, e_exr, e_own, e_busy, 1'b0};
        return v;
    endfunction

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; ex_req = 0; ex_we = 0; ex_addr = 0;
        ex_wdata = 0; mem_ack = 0; mem_rdata = 0;
    endtask

    initial begin
        int n;
        int cyc;
        int pulses;
        logic own_seen [6];
        logic exp_own [6];

        rst = 1'b1;
        idle_inputs();
        #3;
        check("reset_outputs", outs(), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        //          req/addr inputs                          ack rdata    | mreq we addr wdata    ifr exr if_rdata ex_rdata own busy
        tv[0]  = mk(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);
        tv[1]  = mk(0, 8'h00, 1, 0, 8'h10, 16'h0000, 0, 16'h0000, 1, 0, 8'h10, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 1);
        tv[2]  = mk(0, 8'h00, 1, 0, 8'h10, 16'h0000, 1, 16'h1234, 0, 0, 8'h10, 16'h0000, 0, 1, 16'h0000, 16'h1234, 1, 1);
        tv[3]  = mk(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 0, 8'h10, 16'h0000, 0, 0, 16'h0000, 16'h1234, 1, 0);
        tv[4]  = mk(0, 8'h00, 1, 1, 8'h20, 16'hBEEF, 0, 16'h0000, 1, 1, 8'h20, 16'hBEEF, 0, 0, 16'h0000, 16'h1234, 1, 1);
        tv[5]  = mk(0, 8'h00, 1, 1, 8'h20, 16'hBEEF, 1, 16'h5555, 0, 1, 8'h20, 16'hBEEF, 0, 1, 16'h0000, 16'h1234, 1, 1);
        tv[6]  = mk(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 1, 8'h20, 16'hBEEF, 0, 0, 16'h0000, 16'h1234, 1, 0);
        tv[7]  = mk(1, 8'h33, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 0, 8'h33, 16'hBEEF, 0, 0, 16'h0000, 16'h1234, 0, 1);
        tv[8]  = mk(1, 8'h33, 0, 0, 8'h00, 16'h0000, 1, 16'hABCD, 0, 0, 8'h33, 16'hBEEF, 1, 0, 16'hABCD, 16'h1234, 0, 1);
        tv[9]  = mk(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 0, 8'h33, 16'hBEEF, 0, 0, 16'hABCD, 16'h1234, 0, 0);
        tv[10] = mk(1, 8'h44, 1, 0, 8'h50, 16'h0000, 0, 16'h0000, 1, 0, 8'h50, 16'h0000, 0, 0, 16'hABCD, 16'h1234, 1, 1);
        tv[11] = mk(1, 8'h44, 1, 0, 8'h50, 16'h0000, 1, 16'h0505, 0, 0, 8'h50, 16'h0000, 0, 1, 16'hABCD, 16'h0505, 1, 1);
        tv[12] = mk(1, 8'h44, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 0, 8'h50, 16'h0000, 0, 0, 16'hABCD, 16'h0505, 1, 0);
        tv[13] = mk(1, 8'h44, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 0, 8'h44, 16'h0000, 0, 0, 16'hABCD, 16'h0505, 0, 1);
        tv[14] = mk(1, 8'h44, 0, 0, 8'h00, 16'h0000, 1, 16'h4444, 0, 0, 8'h44, 16'h0000, 1, 0, 16'h4444, 16'h0505, 0, 1);
        tv[15] = mk(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 0, 8'h44, 16'h0000, 0, 0, 16'h4444, 16'h0505, 0, 0);

        for (int i = 0; i < 16; i++) begin
            if_req = tv[i].if_req;   if_addr = tv[i].if_addr;
            ex_req = tv[i].ex_req;   ex_we   = tv[i].ex_we;
            ex_addr = tv[i].ex_addr; ex_wdata = tv[i].ex_wdata;
            mem_ack = tv[i].ack;     mem_rdata = tv[i].rdata;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), outs(), tv[i].exp);
        end
        idle_inputs();

        // Contention: both held, memory acks the cycle after mem_req.
        exp_own[0] = 1; exp_own[1] = 1; exp_own[2] = 1;
        exp_own[3] = 1; exp_own[4] = 0; exp_own[5] = 1;
        if_req = 1; if_addr = 8'h01; ex_req = 1; ex_addr = 8'h02; ex_we = 0;
        n = 0;
        for (cyc = 0; cyc < 40 && n < 6; cyc++) begin
            @(posedge clk); #1;
            if (mem_req && !mem_ack) begin
                own_seen[n] = owner;
                n++;
                mem_ack = 1; mem_rdata = 16'h00C0;
            end else begin
                mem_ack = 0;
            end
        end
        check("contention_grants", 64'(n), 64'd6);
        for (int k = 0; k < n; k++)
            check($sformatf("grant%0d_owner", k), 64'(own_seen[k]), 64'(exp_own[k]));
        if_req = 0; ex_req = 0;
        @(posedge clk); #1; mem_ack = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Slow memory: ack 6 cycles late, request must hold steady.
        ex_req = 1; ex_we = 0; ex_addr = 8'h77;
        @(posedge clk); #1;
        check("slow_start", 64'({mem_req, mem_addr}), 64'({1'b1, 8'h77}));
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("slow_hold%0d", k), 64'({mem_req, mem_addr, ex_ready}), 64'({1'b1, 8'h77, 1'b0}));
        end
        mem_ack = 1; mem_rdata = 16'h7777;
        @(posedge clk); #1;
        mem_ack = 0; ex_req = 0;
        check("slow_resp", 64'({ex_ready, ex_rdata}), 64'({1'b1, 16'h7777}));
        if (ex_ready) pulses++;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (ex_ready || if_ready) pulses++;
        end
        check("slow_pulses", 64'(pulses), 64'd1);

        // Reset two cycles into BUSY, then a stale ack.
        ex_req = 1; ex_we = 0; ex_addr = 8'h88;
        @(posedge clk); #1;
        check("rst_req_up", 64'(mem_req), 64'd1);
        @(posedge clk); @(posedge clk); #2;
        rst = 1;
        #1;
        check("rst_async", 64'({mem_req, busy, ex_ready, owner, mem_addr, ex_rdata}), 64'd0);
        ex_req = 0;
        @(posedge clk); #1;
        rst = 0; mem_ack = 1; mem_rdata = 16'h9999;
        @(posedge clk); #1;
        mem_ack = 0;
        pulses = 0;
        if (ex_ready || if_ready || mem_req || busy) pulses++;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (ex_ready || if_ready || mem_req || busy) pulses++;
        end
        check("rst_late_ack", 64'({pulses[7:0], ex_rdata}), 64'd0);

`ifdef MEM_TIMEOUT_EN
        // Timeout: no ack ever; abort after 15 BUSY cycles.
        if_req = 1; if_addr = 8'h09;
        @(posedge clk); #1;
        check("tmo_start", 64'(mem_req), 64'd1);
        n = 0;
        for (cyc = 0; cyc < 30 && !if_ready; cyc++) begin
            @(posedge clk); #1;
            n++;
        end
        if_req = 0;
        check("tmo_cycles", 64'(n), 64'd15);
        check("tmo_resp", 64'({if_ready, err, mem_req, if_rdata}), 64'({1'b1, 1'b1, 1'b0, 16'hDEAD}));
        @(posedge clk); #1;
        check("tmo_after", 64'({if_ready, err, busy}), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported 256x16 data/instruction memory between two requesters: the instruction fetch unit (IF, read-only) and the execute/store-back stage (EX, load/store).
- Serialises accesses, routes read data back to the winner, and prevents fetch starvation.
- Sits between the pipeline stages and the memory model. It replaces direct readReq/valueReady wiring with a uniform req/ready handshake.

Parameters:
- ADDR_W, 8: memory address width.
- DATA_W, 16: memory data width.
- STARVE_MAX, 4: consecutive EX grants, while IF is waiting, that force the next grant to IF. Legal range 1..15.
- TIMEOUT, 15: cycles in BUSY without mem_ack before abort. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch read request (level).
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch read data; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse to IF.
- ex_req  in  1  execute request (level).
- ex_we  in  1  1 = store, 0 = load.
- ex_addr  in  ADDR_W  load/store address.
- ex_wdata  in  DATA_W  store data.
- ex_rdata  out  DATA_W  load data; valid while ex_ready=1.
- ex_ready  out  1  one-cycle completion pulse to EX.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion; single-cycle or held.
- owner  out  1  0 = IF, 1 = EX; registered owner of the current or last transaction.
- busy  out  1  1 in BUSY or RESP.
- err  out  1  timeout abort flag; valid with the ready pulse.

Behaviour:
- Reset (async, mid-transaction included):
  - state goes to IDLE.
  - mem_req, mem_we, if_ready, ex_ready, err, busy, owner all go to 0.
  - mem_addr, mem_wdata, if_rdata, ex_rdata go to 0.
  - Starvation counter goes to 0.
  - Any in-flight access is dropped silently. A late mem_ack after reset is ignored because state is IDLE.
- State machine: IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - Arbitrate on sampled if_req and ex_req.
  - Neither asserted: stay in IDLE.
  - Only one asserted: that requester wins.
  - Both asserted: EX wins, unless starve_cnt == STARVE_MAX, in which case IF wins.
  - On a win, the winner's addr/we/wdata are latched into the mem_* registers, mem_req=1, owner is set, and state goes to BUSY.
  - IF transactions always drive mem_we=0.
- Starvation counter:
  - Increments on an EX grant while if_req=1, saturating at STARVE_MAX.
  - Clears on any IF grant.
  - Unchanged on an EX grant with if_req=0.
- BUSY:
  - mem_req and the mem_* registers are held stable.
  - When mem_ack=1 at posedge: mem_req=0; if load, mem_rdata is latched into the owner's rdata register; the owner's ready=1; state goes to RESP.
  - The non-owner's rdata register is never modified. A store leaves ex_rdata unchanged.
- RESP:
  - Exactly one cycle with the owner's ready=1; then ready=0 and state returns to IDLE.
- Requester rule: a requester holds req and its address/data stable until it samples ready=1, then deasserts req in the next cycle. The arbiter does not re-arbitrate until IDLE, so a correctly dropped req is never re-issued.
- Latency:
  - Minimum request-to-ready is 2 edges: edge0 IDLE->BUSY, edge1 with mem_ack -> RESP.
  - Back-to-back throughput is one transaction per 3 cycles.
- Simultaneous events:
  - A request arriving while BUSY or RESP waits; it is not lost.
  - Both requests arriving in the same cycle follow the IDLE arbitration rule.
- rdata registers hold their last value between transactions.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Enabled:
  - A 4-bit wait counter clears on entry to BUSY and increments each BUSY cycle.
  - On reaching TIMEOUT without mem_ack: mem_req=0, owner's ready=1, err=1 for that RESP cycle, owner's rdata = 16'hDEAD, state goes to RESP.
- Disabled: err is tied to 0 and BUSY waits indefinitely for mem_ack.

Decomposition:
- Package mem_arb_pkg: state encoding (ST_IDLE=2'd0, ST_BUSY=2'd1, ST_RESP=2'd2), owner codes (OWN_IF=1'b0, OWN_EX=1'b1), TIMEOUT_DATA=16'hDEAD.
- One sub-module, arb_starve_ctr: the saturating starvation counter. Inputs are grant_if, grant_ex and if_waiting; output is force_if.

Test Plan:
- Single load: ex_req=1, ex_we=0, ex_addr=8'h10; memory acks in the cycle after mem_req with mem_rdata=16'h1234 -> mem_addr=8'h10, mem_we=0; ex_ready pulses 1 cycle with ex_rdata=16'h1234 two edges after the request; if_ready stays 0.
- Store: ex_we=1, ex_addr=8'h20, ex_wdata=16'hBEEF -> mem_we=1, mem_wdata=16'hBEEF; ex_ready pulse; ex_rdata unchanged from previous value.
- Contention: if_req and ex_req both held continuously with STARVE_MAX=4 -> grant order EX, EX, EX, EX, IF, EX, ... observed on owner.
- Slow memory: mem_ack delayed 6 cycles -> mem_req and mem_addr stable for all 6 cycles; exactly one ready pulse.
- Reset mid-BUSY: assert rst 2 cycles after mem_req rises, then give a late mem_ack -> mem_req=0 immediately (async), no ready pulse, state IDLE.
- MEM_TIMEOUT_EN with TIMEOUT=15, mem_ack never asserted -> after 15 BUSY cycles, if_ready=1, err=1, if_rdata=16'hDEAD.
